// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Host write port and CPU instruction-load port of imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
);
    logic          wr_valid;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          start;
    logic          clear;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          CpuReset;
    logic          LoadInstructions;
    logic [31:0]   Instruction;

    modport master (
        output wr_valid, wr_data, start, clear,
        input  wr_ready, word_count, busy, done, CpuReset, LoadInstructions, Instruction
    );

    modport slave (
        input  wr_valid, wr_data, start, clear,
        output wr_ready, word_count, busy, done, CpuReset, LoadInstructions, Instruction
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Buffers host instruction words and streams them into the CPU
//               load port, wrapping the stream in CPU reset pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          Reset,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE_RST  = 3'd1,
        S_LOAD     = 3'd2,
        S_POST_RST = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   idx_q,   idx_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          load_q,    load_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [31:0]   instr_q,   instr_d;
    logic [31:0]   mem_q [DEPTH];

    logic          w_wr_ready;
    logic          w_wr_fire;

    assign w_wr_ready = (state_q == S_IDLE) && (count_q < C_FULL)
                        && !bus.start && !bus.clear;
    assign w_wr_fire  = w_wr_ready && bus.wr_valid;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem_q[count_q[AW-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    count_d = '0;
                end else if (bus.start && (count_q != '0)) begin
                    state_d = S_PRE_RST;
                    idx_d   = '0;
                end else if (w_wr_fire) begin
                    count_d = count_q + C_ONE;
                end
            end
            S_PRE_RST: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (idx_q == count_q) begin
                    state_d = S_POST_RST;
                end
            end
            S_POST_RST: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.clear) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (bus.start) begin
                    state_d = S_PRE_RST;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        if (state_d == S_LOAD) begin
            idx_d = idx_q + C_ONE;
        end

        cpu_rst_d = (state_d == S_IDLE) || (state_d == S_PRE_RST) || (state_d == S_POST_RST);
        load_d    = (state_d == S_LOAD);
        busy_d    = (state_d == S_PRE_RST) || (state_d == S_LOAD) || (state_d == S_POST_RST);
        done_d    = (state_d == S_DONE);
        instr_d   = (state_d == S_LOAD) ? mem_q[idx_q[AW-1:0]] : 32'h0;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            cpu_rst_q <= 1'b1;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            cpu_rst_q <= cpu_rst_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            instr_q   <= instr_d;
        end
    end

    assign bus.wr_ready         = w_wr_ready;
    assign bus.word_count       = count_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.CpuReset         = cpu_rst_q;
    assign bus.LoadInstructions = load_q;
    assign bus.Instruction      = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader load-sequence behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    imem_loader_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          busy_cnt = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_w;
    logic [31:0] prog_basic [3] = '{32'h20010005, 32'h20020003, 32'h00221820};
    logic [31:0] prog_two   [2] = '{32'h11111111, 32'h22222222};
    logic [31:0] prog_four  [4] = '{32'h8C010000, 32'h8C020004, 32'h00221820, 32'hAC030008};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented word is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.LoadInstructions === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL load_unexpected: got %h expected no word at %0t", bus.Instruction, $time);
            end else begin
                mon_w = exp_q.pop_front();
                chk("load_word", bus.Instruction, mon_w);
            end
        end else begin
            chk("instr_zero_when_idle", bus.Instruction, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.wr_valid = 1'b1;
        bus.wr_data  = w;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic run_seq(input int n, input bit with_write, input logic [31:0] wdat);
        int b0;
        bus.start = 1'b1;
        if (with_write) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = wdat;
            sample();
            chk("wr_ready_during_start", {31'h0, bus.wr_ready}, 32'h0);
        end
        b0 = busy_cnt;
        tick();
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        sample();
        chk("pre_cpureset", {31'h0, bus.CpuReset}, 32'h1);
        chk("pre_load",     {31'h0, bus.LoadInstructions}, 32'h0);
        chk("pre_busy",     {31'h0, bus.busy}, 32'h1);
        for (int k = 0; k < n; k++) begin
            tick();
            sample();
            chk("load_flag",     {31'h0, bus.LoadInstructions}, 32'h1);
            chk("load_cpureset", {31'h0, bus.CpuReset}, 32'h0);
        end
        tick();
        sample();
        chk("post_cpureset", {31'h0, bus.CpuReset}, 32'h1);
        chk("post_load",     {31'h0, bus.LoadInstructions}, 32'h0);
        tick();
        sample();
        chk("done_flag",     {31'h0, bus.done}, 32'h1);
        chk("done_cpureset", {31'h0, bus.CpuReset}, 32'h0);
        chk("done_busy",     {31'h0, bus.busy}, 32'h0);
        chk("busy_cycles",   busy_cnt - b0, n + 2);
        chk("queue_drained", exp_q.size(), 32'h0);
    endtask

    initial begin
        Reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'h0;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;

        // Reset state
        repeat (2) tick();
        sample();
        chk("rst_cpureset",   {31'h0, bus.CpuReset}, 32'h1);
        chk("rst_load",       {31'h0, bus.LoadInstructions}, 32'h0);
        chk("rst_word_count", {26'h0, bus.word_count}, 32'h0);
        chk("rst_busy",       {31'h0, bus.busy}, 32'h0);
        chk("rst_done",       {31'h0, bus.done}, 32'h0);
        tick();
        Reset = 1'b0;
        sample();
        chk("idle_wr_ready", {31'h0, bus.wr_ready}, 32'h1);

        // Basic three-word load
        for (int i = 0; i < 3; i++) push_word(prog_basic[i]);
        sample();
        chk("basic_word_count", {26'h0, bus.word_count}, 32'd3);
        for (int i = 0; i < 3; i++) exp_q.push_back(prog_basic[i]);
        run_seq(3, 1'b0, 32'h0);

        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        sample();
        chk("clear_word_count", {26'h0, bus.word_count}, 32'h0);
        chk("clear_done",       {31'h0, bus.done}, 32'h0);
        chk("clear_cpureset",   {31'h0, bus.CpuReset}, 32'h1);

        // Fill past capacity with back-to-back offers
        tick();
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hA0000000 + 32'(i);
            sample();
            if (i == DEPTH - 1) chk("full_last_ready", {31'h0, bus.wr_ready}, 32'h1);
            if (i == DEPTH)     chk("full_ready_low",  {31'h0, bus.wr_ready}, 32'h0);
            tick();
        end
        bus.wr_valid = 1'b0;
        sample();
        chk("full_word_count", {26'h0, bus.word_count}, 32'd32);
        chk("full_wr_ready",   {31'h0, bus.wr_ready}, 32'h0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'hA0000000 + 32'(i));
        tick();
        run_seq(DEPTH, 1'b0, 32'h0);

        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;

        // Start on an empty buffer is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        sample();
        chk("empty_start_busy",     {31'h0, bus.busy}, 32'h0);
        chk("empty_start_cpureset", {31'h0, bus.CpuReset}, 32'h1);
        chk("empty_start_count",    {26'h0, bus.word_count}, 32'h0);

        // Start beats a simultaneous write
        tick();
        for (int i = 0; i < 2; i++) push_word(prog_two[i]);
        for (int i = 0; i < 2; i++) exp_q.push_back(prog_two[i]);
        run_seq(2, 1'b1, 32'h33333333);
        chk("start_write_count", {26'h0, bus.word_count}, 32'd2);

        // Replay from DONE
        tick();
        for (int i = 0; i < 2; i++) exp_q.push_back(prog_two[i]);
        run_seq(2, 1'b0, 32'h0);

        // Clear beats start in DONE
        tick();
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        sample();
        chk("clr_start_busy",     {31'h0, bus.busy}, 32'h0);
        chk("clr_start_done",     {31'h0, bus.done}, 32'h0);
        chk("clr_start_count",    {26'h0, bus.word_count}, 32'h0);
        chk("clr_start_cpureset", {31'h0, bus.CpuReset}, 32'h1);

        // Asynchronous reset during the second LOAD cycle
        tick();
        for (int i = 0; i < 4; i++) push_word(prog_four[i]);
        exp_q.push_back(prog_four[0]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("midload_word1", bus.Instruction, prog_four[1]);
        #1 Reset = 1'b1;
        #1;
        chk("midload_rst_load",     {31'h0, bus.LoadInstructions}, 32'h0);
        chk("midload_rst_cpureset", {31'h0, bus.CpuReset}, 32'h1);
        chk("midload_rst_count",    {26'h0, bus.word_count}, 32'h0);
        chk("midload_rst_busy",     {31'h0, bus.busy}, 32'h0);
        tick();
        Reset = 1'b0;
        sample();
        chk("after_rst_busy",     {31'h0, bus.busy}, 32'h0);
        chk("after_rst_done",     {31'h0, bus.done}, 32'h0);
        chk("after_rst_wr_ready", {31'h0, bus.wr_ready}, 32'h1);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        sample();
        chk("after_rst_start_ignored", {31'h0, bus.busy}, 32'h0);
        chk("final_queue_empty", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
